// File: rtl/branch_hazard_unit.sv
// ID-stage branch hazard controller: stalls on producers forwarding cannot reach, flushes IF/ID on taken branches.
// Optional performance counters enabled with `define BRANCH_HAZARD_PERF_EN.
module branch_hazard_unit #(
    parameter int MAX_STALL = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       Branch_in,
    input  logic       Uses_rs2,
    input  logic [4:0] IFID_RegisterRs1,
    input  logic [4:0] IFID_RegisterRs2,
    input  logic       IDEX_RegWrite,
    input  logic       IDEX_MemRead,
    input  logic [4:0] IDEX_RegisterRd,
    input  logic       EXMEM_RegWrite,
    input  logic       EXMEM_MemRead,
    input  logic [4:0] EXMEM_RegisterRd,
    input  logic       Branch_taken,
    output logic       PC_write,
    output logic       IFID_write,
    output logic       IDEX_bubble,
    output logic       IFID_flush
`ifdef BRANCH_HAZARD_PERF_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
`endif
);

    localparam int CNT_W = $clog2(MAX_STALL + 1);

    typedef enum logic [1:0] {RUN, STALL, RESOLVE} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [CNT_W-1:0] need;
    logic [1:0]       need_rs1, need_rs2, need_max;
    logic             stall, flush;

    // Stall cycles one source needs: a load in EX needs two, an ALU result in EX or a load in MEM needs one.
    function automatic logic [1:0] src_need(
        input logic [4:0] rs,
        input logic       idex_rw,
        input logic       idex_mr,
        input logic [4:0] idex_rd,
        input logic       exmem_rw,
        input logic       exmem_mr,
        input logic [4:0] exmem_rd
    );
        logic idex_hit, exmem_hit;
        idex_hit  = idex_rw && (idex_rd != 5'd0) && (idex_rd == rs);
        exmem_hit = exmem_rw && (exmem_rd != 5'd0) && (exmem_rd == rs);
        if (idex_hit)
            return idex_mr ? 2'd2 : 2'd1;
        else if (exmem_hit && exmem_mr)
            return 2'd1;
        else
            return 2'd0;
    endfunction

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        need_rs1 = src_need(IFID_RegisterRs1, IDEX_RegWrite, IDEX_MemRead, IDEX_RegisterRd,
                            EXMEM_RegWrite, EXMEM_MemRead, EXMEM_RegisterRd);
        need_rs2 = 2'd0;
        if (Uses_rs2)
            need_rs2 = src_need(IFID_RegisterRs2, IDEX_RegWrite, IDEX_MemRead, IDEX_RegisterRd,
                                EXMEM_RegWrite, EXMEM_MemRead, EXMEM_RegisterRd);
        need_max = (need_rs1 > need_rs2) ? need_rs1 : need_rs2;
        need     = Branch_in ? CNT_W'(need_max) : '0;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            RUN, RESOLVE: begin
                if (need != '0) begin
                    cnt_next   = need - CNT_W'(1);
                    state_next = (cnt_next != '0) ? STALL : RESOLVE;
                end else begin
                    state_next = RUN;
                end
            end
            STALL: begin
                cnt_next = cnt - CNT_W'(1);
                // A branch withdrawn mid-stall returns to RUN without resolving.
                if (cnt_next == '0)
                    state_next = Branch_in ? RESOLVE : RUN;
            end
            default: begin
                state_next = RUN;
                cnt_next   = '0;
            end
        endcase
    end

    // Stall and flush are mutually exclusive; outputs idle while reset is held.
    always_comb begin
        stall = 1'b0;
        flush = 1'b0;
        if (rst_n) begin
            case (state)
                RUN, RESOLVE: begin
                    if (need != '0)
                        stall = 1'b1;
                    else
                        flush = Branch_in && Branch_taken;
                end
                STALL:   stall = 1'b1;
                default: stall = 1'b0;
            endcase
        end
    end

    assign PC_write    = ~stall;
    assign IFID_write  = ~stall;
    assign IDEX_bubble = stall;
    assign IFID_flush  = flush;

`ifdef BRANCH_HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (IDEX_bubble)
                stall_cycles <= stall_cycles + 32'd1;
            if (IFID_flush)
                flush_count <= flush_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_hazard_unit.sv
// Self-checking bench for branch_hazard_unit: transaction-level model of stall/flush sequences per branch.
// Counter checks compile in when BRANCH_HAZARD_PERF_EN is defined.
module tb_branch_hazard_unit;

    typedef struct packed {
        logic       br;
        logic       u2;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       ix_rw;
        logic       ix_mr;
        logic [4:0] ix_rd;
        logic       xm_rw;
        logic       xm_mr;
        logic [4:0] xm_rd;
        logic       tk;
    } in_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       Branch_in, Uses_rs2, Branch_taken;
    logic [4:0] IFID_RegisterRs1, IFID_RegisterRs2;
    logic       IDEX_RegWrite, IDEX_MemRead, EXMEM_RegWrite, EXMEM_MemRead;
    logic [4:0] IDEX_RegisterRd, EXMEM_RegisterRd;
    logic       PC_write, IFID_write, IDEX_bubble, IFID_flush;
`ifdef BRANCH_HAZARD_PERF_EN
    logic [31:0] stall_cycles, flush_count;
`endif

    int   total = 0;
    int   bad = 0;
    int   bub_seen = 0;
    int   fl_seen = 0;
    logic e_stall = 1'b0;
    logic e_flush = 1'b0;

    branch_hazard_unit dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .Branch_in        (Branch_in),
        .Uses_rs2         (Uses_rs2),
        .IFID_RegisterRs1 (IFID_RegisterRs1),
        .IFID_RegisterRs2 (IFID_RegisterRs2),
        .IDEX_RegWrite    (IDEX_RegWrite),
        .IDEX_MemRead     (IDEX_MemRead),
        .IDEX_RegisterRd  (IDEX_RegisterRd),
        .EXMEM_RegWrite   (EXMEM_RegWrite),
        .EXMEM_MemRead    (EXMEM_MemRead),
        .EXMEM_RegisterRd (EXMEM_RegisterRd),
        .Branch_taken     (Branch_taken),
        .PC_write         (PC_write),
        .IFID_write       (IFID_write),
        .IDEX_bubble      (IDEX_bubble),
        .IFID_flush       (IFID_flush)
`ifdef BRANCH_HAZARD_PERF_EN
        ,
        .stall_cycles     (stall_cycles),
        .flush_count      (flush_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle: {PC_write, IFID_write, IDEX_bubble, IFID_flush} against the model's expectation.
    always @(negedge clk) begin
        check("outputs", {28'd0, PC_write, IFID_write, IDEX_bubble, IFID_flush},
              {28'd0, ~e_stall, ~e_stall, e_stall, e_flush});
        if (IDEX_bubble === 1'b1) bub_seen++;
        if (IFID_flush === 1'b1) fl_seen++;
    end

    // Stall cycles a branch must wait, straight from the hazard rules.
    function automatic int need_of(input in_t t);
        int         best;
        logic [4:0] srcs[2];
        best    = 0;
        srcs[0] = t.rs1;
        srcs[1] = t.rs2;
        if (!t.br) return 0;
        for (int i = 0; i < 2; i++) begin
            int ns;
            ns = 0;
            if (i == 1 && !t.u2) continue;
            if (t.ix_rw && t.ix_rd != 0 && t.ix_rd == srcs[i])
                ns = t.ix_mr ? 2 : 1;
            else if (t.xm_rw && t.xm_mr && t.xm_rd != 0 && t.xm_rd == srcs[i])
                ns = 1;
            if (ns > best) best = ns;
        end
        return best;
    endfunction

    function automatic in_t mk(input logic br, input logic u2, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic ix_rw, input logic ix_mr, input logic [4:0] ix_rd,
                               input logic xm_rw, input logic xm_mr, input logic [4:0] xm_rd, input logic tk);
        in_t t;
        t.br = br; t.u2 = u2; t.rs1 = rs1; t.rs2 = rs2;
        t.ix_rw = ix_rw; t.ix_mr = ix_mr; t.ix_rd = ix_rd;
        t.xm_rw = xm_rw; t.xm_mr = xm_mr; t.xm_rd = xm_rd; t.tk = tk;
        return t;
    endfunction

    // Small register range so matches and x0 cases occur often.
    function automatic in_t rand_in();
        return mk(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)));
    endfunction

    task automatic apply(input in_t t, input logic st, input logic fl);
        Branch_in = t.br; Uses_rs2 = t.u2;
        IFID_RegisterRs1 = t.rs1; IFID_RegisterRs2 = t.rs2;
        IDEX_RegWrite = t.ix_rw; IDEX_MemRead = t.ix_mr; IDEX_RegisterRd = t.ix_rd;
        EXMEM_RegWrite = t.xm_rw; EXMEM_MemRead = t.xm_mr; EXMEM_RegisterRd = t.xm_rd;
        Branch_taken = t.tk;
        e_stall = st;
        e_flush = fl;
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    // One instruction in ID: need stall cycles, then a resolve cycle with producers moved on.
    task automatic run_branch(input in_t t, input bit drop);
        int  n;
        bit  dropped;
        in_t j;
        n       = need_of(t);
        dropped = drop && (n >= 2);
        apply(t, n > 0, (n == 0) && t.br && t.tk);
        for (int k = 1; k < n; k++) begin
            j    = rand_in();
            j.br = !dropped;
            apply(j, 1'b1, 1'b0);
        end
        if (n > 0 && !dropped) begin
            j       = t;
            j.ix_rw = 1'b0;
            j.xm_mr = 1'b0;
            apply(j, 1'b0, t.tk);
        end
    endtask

    task automatic directed(input string name, input in_t t, input int want_stalls, input int want_flush);
        int b0, f0;
        b0 = bub_seen;
        f0 = fl_seen;
        check({name, "_need"}, need_of(t), want_stalls);
        run_branch(t, 1'b0);
        check({name, "_stalls"}, bub_seen - b0, want_stalls);
        check({name, "_flushes"}, fl_seen - f0, want_flush);
    endtask

    initial begin
        in_t idle, t;
        idle  = '0;
        rst_n = 1'b0;
        apply(idle, 1'b0, 1'b0);
        apply(rand_in(), 1'b0, 1'b0);
        rst_n = 1'b1;
        apply(idle, 1'b0, 1'b0);

        directed("load_ex_rs1", mk(1, 0, 5, 0, 1, 1, 5, 0, 0, 0, 1), 2, 1);
        directed("alu_ex_rs2", mk(1, 1, 0, 7, 1, 0, 7, 0, 0, 0, 0), 1, 0);
        directed("alu_ex_rs2_masked", mk(1, 0, 0, 7, 1, 0, 7, 0, 0, 0, 1), 0, 1);
        directed("load_mem_rs1", mk(1, 0, 3, 0, 0, 0, 0, 1, 1, 3, 1), 1, 1);
        directed("x0_ignored", mk(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0), 0, 0);
        directed("max_of_sources", mk(1, 1, 4, 6, 1, 1, 6, 1, 1, 4, 1), 2, 1);
        directed("no_branch", mk(0, 1, 5, 5, 1, 1, 5, 1, 1, 5, 1), 0, 0);

        // Reset during the STALL cycle of a load-use stall.
        t = mk(1, 0, 5, 0, 1, 1, 5, 0, 0, 0, 1);
        apply(t, 1'b1, 1'b0);
        rst_n = 1'b0;
        apply(t, 1'b0, 1'b0);
        rst_n = 1'b1;
        t.br = 1'b0;
        apply(t, 1'b0, 1'b0);
`ifdef BRANCH_HAZARD_PERF_EN
        check("rst_stall_cycles", stall_cycles, 32'd0);
`endif
        apply(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1), 1'b0, 1'b1);

`ifdef BRANCH_HAZARD_PERF_EN
        rst_n = 1'b0;
        apply(idle, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++)
            run_branch(mk(1, 0, 5, 0, 1, 1, 5, 0, 0, 0, 1), 1'b0);
        check("perf_stall_cycles", stall_cycles, 32'd6);
        check("perf_flush_count", flush_count, 32'd3);
`endif

        for (int i = 0; i < 400; i++)
            run_branch(rand_in(), $urandom_range(0, 3) == 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
